// File: rtl/msx_reset_seq_pkg.sv
// Shared MSX definitions: cartridge config record and reset sequencer constants.
package MSX;

  // Cartridge configuration as produced by the configuration stage.
  typedef struct packed {
    logic [7:0] mapper_type;
    logic [7:0] selected_sram_size;
  } config_cart_t;

  // Reset sequencer states.
  typedef enum logic [1:0] {
    RS_IDLE     = 2'd0,
    RS_HOLD     = 2'd1,
    RS_CLEAR    = 2'd2,
    RS_WAIT_RDY = 2'd3
  } reset_state_t;

  localparam int unsigned HOLD_CYCLES_DEFAULT = 1024;
  localparam logic [7:0]  SRAM_CLEAR_MAX_KB   = 8'd32;

  // Clamp the requested SRAM size to the largest region the clear can cover.
  function automatic logic [5:0] clamp_sram_kb(input logic [7:0] kb);
    logic [5:0] r;
    if (kb > SRAM_CLEAR_MAX_KB) r = 6'd32;
    else                        r = kb[5:0];
    return r;
  endfunction

endpackage

// File: rtl/msx_reset_seq.sv
// MSX reset sequencer: holds the core in reset, fills cartridge SRAM with a
// constant, then waits for the memory controller before releasing reset.
module msx_reset_seq
  import MSX::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter logic [7:0]  FILL        = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reload,
  input  logic        hps_reset,
  input  logic [7:0]  sram_size,
  input  logic        sdram_ready,
  output logic        msx_reset,
  output logic [14:0] clr_addr,
  output logic [7:0]  clr_data,
  output logic        clr_req,
  input  logic        clr_ack,
  output logic        busy
);

  localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  reset_state_t   state, state_nx;
  logic [HCW-1:0] hold_cnt, hold_nx;
  logic [15:0]    addr_cnt, addr_nx;
  logic [5:0]     size_eff, size_nx;
  logic           pending, pend_nx;
  logic           req_nx;
  logic           restart;
  logic [5:0]     size_clamped;
  logic [15:0]    last_addr;

  assign restart      = reload | hps_reset;
  assign size_clamped = clamp_sram_kb(sram_size);
  assign last_addr    = {size_eff, 10'd0} - 16'd1;

  assign clr_addr = addr_cnt[14:0];
  assign clr_data = FILL;
  assign busy     = (state != RS_IDLE);

  // Next-state and datapath decisions for the sequencer.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    addr_nx  = addr_cnt;
    size_nx  = size_eff;
    pend_nx  = pending;
    req_nx   = clr_req;
    unique case (state)
      RS_IDLE: begin
        if (restart) begin
          state_nx = RS_HOLD;
          hold_nx  = '0;
        end
      end
      RS_HOLD: begin
        if (restart) begin
          hold_nx = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          size_nx = size_clamped;
          if (size_clamped != 6'd0) begin
            state_nx = RS_CLEAR;
            addr_nx  = '0;
            req_nx   = 1'b1;
          end else begin
            state_nx = RS_WAIT_RDY;
          end
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      RS_CLEAR: begin
        // A restart during a write is deferred until that write is acknowledged.
        if (restart) pend_nx = 1'b1;
        if (clr_req && clr_ack) begin
          addr_nx = addr_cnt + 16'd1;
          if (pending || restart) begin
            state_nx = RS_HOLD;
            hold_nx  = '0;
            req_nx   = 1'b0;
            pend_nx  = 1'b0;
          end else if (addr_cnt == last_addr) begin
            state_nx = RS_WAIT_RDY;
            req_nx   = 1'b0;
          end
        end
      end
      RS_WAIT_RDY: begin
        if (restart) begin
          state_nx = RS_HOLD;
          hold_nx  = '0;
        end else if (sdram_ready) begin
          state_nx = RS_IDLE;
        end
      end
      default: begin
        state_nx = RS_IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

  // State registers; msx_reset is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RS_IDLE;
      msx_reset <= 1'b1;
      clr_req   <= 1'b0;
      addr_cnt  <= '0;
      hold_cnt  <= '0;
      size_eff  <= '0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nx;
      msx_reset <= (state_nx != RS_IDLE);
      clr_req   <= req_nx;
      addr_cnt  <= addr_nx;
      hold_cnt  <= hold_nx;
      size_eff  <= size_nx;
      pending   <= pend_nx;
    end
  end

endmodule

// File: tb/tb_msx_reset_seq.sv
// Scoreboard bench for msx_reset_seq: stimulus queues expected write
// addresses, a monitor pops them as the DUT's writes are acknowledged.
module tb_msx_reset_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reload = 1'b0;
  logic        hps_reset = 1'b0;
  logic [7:0]  sram_size = 8'd0;
  logic        sdram_ready = 1'b1;
  logic        clr_ack = 1'b0;
  logic        msx_reset;
  logic [14:0] clr_addr;
  logic [7:0]  clr_data;
  logic        clr_req;
  logic        busy;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [14:0] exp_q[$];
  int unsigned n_writes = 0;
  logic [14:0] last_wr = '0;
  bit          ack_gap = 1'b0;
  bit          force_ack = 1'b0;

  logic        prev_req = 1'b0;
  logic        prev_acc = 1'b0;
  logic        prev_rst = 1'b1;
  logic [14:0] prev_addr = '0;

  msx_reset_seq #(.HOLD_CYCLES(16), .FILL(8'hFF)) dut (
    .clk(clk), .reset(reset), .reload(reload), .hps_reset(hps_reset),
    .sram_size(sram_size), .sdram_ready(sdram_ready), .msx_reset(msx_reset),
    .clr_addr(clr_addr), .clr_data(clr_data), .clr_req(clr_req),
    .clr_ack(clr_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic push_range(input int unsigned lo, input int unsigned hi);
    for (int unsigned a = lo; a <= hi; a++) exp_q.push_back(15'(a));
  endtask

  task automatic wait_idle(input int unsigned max, input string name);
    for (int unsigned i = 0; i < max && busy; i++) tick();
    chk(name, 32'(busy), 32'd0);
  endtask

  // Acknowledge responder: continuous, or with one idle cycle between acks.
  initial begin
    forever begin
      @(negedge clk);
      if (force_ack)    clr_ack = 1'b1;
      else if (ack_gap) clr_ack = clr_req && !clr_ack;
      else              clr_ack = clr_req;
    end
  end

  // Monitor: every accepted write is popped against the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (prev_req && !prev_acc && !prev_rst && clr_req)
        chk("addr_stable", 32'(clr_addr), 32'(prev_addr));
      if (clr_req && clr_ack && !reset) begin
        n_writes++;
        last_wr = clr_addr;
        chk("wr_data", 32'(clr_data), 32'h0000_00FF);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_unexpected: got write to %0h, expected none", clr_addr);
        end else begin
          chk("wr_addr", 32'(clr_addr), 32'(exp_q.pop_front()));
        end
      end
      prev_req  = clr_req;
      prev_acc  = clr_req && clr_ack && !reset;
      prev_rst  = reset;
      prev_addr = clr_addr;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned hi;
    int unsigned w0;
    bit          req_seen;
    int unsigned i;

    // Reset state.
    tick();
    chk("rst_msx_reset", 32'(msx_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clr_req", 32'(clr_req), 32'd0);
    chk("rst_clr_addr", 32'(clr_addr), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_msx_reset", 32'(msx_reset), 32'd0);

    // sram_size=0: 16 hold cycles plus one WAIT_RDY cycle, no writes.
    sram_size = 8'd0;
    w0 = n_writes;
    hi = 0;
    req_seen = 1'b0;
    reload = 1'b1;
    for (i = 0; i < 100; i++) begin
      tick();
      if (i == 0) reload = 1'b0;
      if (clr_req) req_seen = 1'b1;
      if (msx_reset) hi++;
      else if (hi > 0) break;
    end
    chk("size0_reset_cycles", hi, 32'd17);
    chk("size0_no_req", 32'(req_seen), 32'd0);
    chk("size0_no_writes", n_writes - w0, 32'd0);

    // 1 kB clear with gapped acks; sram_size change after latch is ignored.
    ack_gap = 1'b1;
    sram_size = 8'd1;
    push_range(0, 1023);
    w0 = n_writes;
    pulse_reload();
    for (i = 0; i < 100 && !clr_req; i++) tick();
    chk("kb1_req_seen", 32'(clr_req), 32'd1);
    sram_size = 8'd64;
    wait_idle(5000, "kb1_done");
    chk("kb1_writes", n_writes - w0, 32'd1024);
    chk("kb1_last_addr", 32'(last_wr), 32'd1023);
    chk("kb1_q_empty", 32'(exp_q.size()), 32'd0);

    // Restart at addr 100: write 100 completes, then a full clear from 0.
    sram_size = 8'd1;
    push_range(0, 100);
    push_range(0, 1023);
    w0 = n_writes;
    pulse_reload();
    for (i = 0; i < 1000 && !(clr_req && clr_addr == 15'd100 && !clr_ack); i++) tick();
    chk("rst100_reached", 32'(clr_addr), 32'd100);
    hps_reset = 1'b1;
    tick();
    hps_reset = 1'b0;
    chk("rst100_req_held", 32'(clr_req), 32'd1);
    chk("rst100_addr_held", 32'(clr_addr), 32'd100);
    tick();
    chk("rst100_req_drop", 32'(clr_req), 32'd0);
    chk("rst100_busy", 32'(busy), 32'd1);
    chk("rst100_msx_reset", 32'(msx_reset), 32'd1);
    wait_idle(5000, "rst100_done");
    chk("rst100_writes", n_writes - w0, 32'd1125);
    chk("rst100_q_empty", 32'(exp_q.size()), 32'd0);

    // 2 kB clear, sdram_ready low 50 cycles after the clear.
    ack_gap = 1'b0;
    sdram_ready = 1'b0;
    sram_size = 8'd2;
    push_range(0, 2047);
    w0 = n_writes;
    pulse_reload();
    for (i = 0; i < 100 && !clr_req; i++) tick();
    for (i = 0; i < 5000 && clr_req; i++) tick();
    chk("rdy_clear_ended", 32'(clr_req), 32'd0);
    hi = 0;
    for (i = 0; i < 50; i++) begin
      tick();
      if (msx_reset) hi++;
    end
    chk("rdy_held_cycles", hi, 32'd50);
    sdram_ready = 1'b1;
    chk("rdy_still_reset", 32'(msx_reset), 32'd1);
    tick();
    chk("rdy_released", 32'(msx_reset), 32'd0);
    chk("rdy_busy", 32'(busy), 32'd0);
    chk("rdy_writes", n_writes - w0, 32'd2048);
    chk("rdy_q_empty", 32'(exp_q.size()), 32'd0);

    // sram_size=64 clamps to 32 kB: 32768 writes ending at 7FFF.
    sram_size = 8'd64;
    push_range(0, 32767);
    w0 = n_writes;
    pulse_reload();
    wait_idle(40000, "kb32_done");
    chk("kb32_writes", n_writes - w0, 32'd32768);
    chk("kb32_last_addr", 32'(last_wr), 32'h7FFF);
    chk("kb32_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-clear with an ack pending; a stray ack afterwards is ignored.
    ack_gap = 1'b1;
    sram_size = 8'd1;
    push_range(0, 4);
    pulse_reload();
    for (i = 0; i < 200 && !(clr_req && clr_addr == 15'd5 && clr_ack); i++) tick();
    chk("midrst_reached", 32'(clr_addr), 32'd5);
    reset = 1'b1;
    tick();
    chk("midrst_req", 32'(clr_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(clr_addr), 32'd0);
    chk("midrst_msx_reset", 32'(msx_reset), 32'd1);
    reset = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    chk("stray_ack_addr", 32'(clr_addr), 32'd0);
    chk("stray_ack_req", 32'(clr_req), 32'd0);
    chk("stray_ack_busy", 32'(busy), 32'd0);
    chk("stray_ack_msx_reset", 32'(msx_reset), 32'd0);
    tick();
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msx_reset_seq.md
MSX_RESET_SEQ -- requirements
Module: msx_reset_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 1024, number of clk cycles reset is held before clearing.
REQ-002 Parameter FILL, default 8'hFF, byte written to every cleared SRAM location.
REQ-003 Port clk  input  1  system clock; the block uses this single clock only.
REQ-004 Port reset  input  1  synchronous, active-high block reset.
REQ-005 Port reload  input  1  config-change request, level or pulse, from the cartridge configuration stage.
REQ-006 Port hps_reset  input  1  user/HPS reset request.
REQ-007 Port sram_size  input  8  size to clear in kB, same encoding as cart selected_sram_size; 0 means no clear.
REQ-008 Port sdram_ready  input  1  memory controller initialised.
REQ-009 Port msx_reset  output  1  reset to the MSX core.
REQ-010 Port clr_addr  output  15  byte address of the current clear write.
REQ-011 Port clr_data  output  8  write data, always FILL.
REQ-012 Port clr_req  output  1  write request, held until acknowledged.
REQ-013 Port clr_ack  input  1  one-cycle write acknowledge.
REQ-014 Port busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, HOLD, CLEAR and WAIT_RDY.
REQ-016 In IDLE, reload or hps_reset sampled high SHALL move the FSM to HOLD on the next edge and clear the hold counter to 0.
REQ-017 msx_reset SHALL be high in HOLD, CLEAR and WAIT_RDY and low in IDLE, as a registered output.
REQ-018 HOLD SHALL increment its counter each cycle and leave when the count reaches HOLD_CYCLES-1, giving exactly HOLD_CYCLES cycles in HOLD.
REQ-019 On leaving HOLD, the FSM SHALL latch size_eff = min(sram_size, 32); it SHALL go to CLEAR if size_eff != 0, else to WAIT_RDY.
REQ-020 CLEAR SHALL write addresses 0 .. size_eff*1024-1 in ascending order, one write per clr_ack.
REQ-021 clr_req SHALL be asserted on the cycle CLEAR is entered.
REQ-022 clr_addr and clr_data SHALL be stable while clr_req is high.
REQ-023 On clr_ack, clr_addr SHALL advance on the same edge.
REQ-024 On clr_ack for the last address, clr_req SHALL drop on the next cycle and the FSM SHALL go to WAIT_RDY.
REQ-025 clr_ack while clr_req is low SHALL be ignored.
REQ-026 The address counter SHALL be 16 bits internally so that 32768 is detected without wrap; clr_addr is its low 15 bits.
REQ-027 WAIT_RDY SHALL go to IDLE on the first cycle sdram_ready is high; msx_reset falls on that edge.
REQ-028 Restart in HOLD or WAIT_RDY: a new reload or hps_reset SHALL send the FSM to HOLD with the counter cleared.
REQ-029 Restart in CLEAR: a new reload or hps_reset SHALL set a pending flag; the outstanding write completes; on its clr_ack the FSM SHALL go to HOLD instead of continuing, and the flag clears.
REQ-030 Requests arriving in IDLE on the same cycle as a transition SHALL NOT be lost: a level still high at the next IDLE cycle SHALL retrigger.
REQ-031 sram_size changes after it is latched SHALL NOT affect the clear in progress.

Reset
REQ-032 reset SHALL force state IDLE, msx_reset=1 for one cycle then follow REQ-017, clr_req=0, clr_addr=0, busy=0, pending flag=0 and counters=0.
REQ-033 reset asserted mid-CLEAR SHALL drop clr_req on the next edge; a late clr_ack SHALL be ignored.

Structure
REQ-034 The state enum, the 32 kB clear limit and the default HOLD_CYCLES SHALL live in package MSX, next to config_cart_t.
REQ-035 The block SHALL be a single module with no sub-module.
REQ-036 The block SHALL be instantiated between msx_config.reload and the core reset and SRAM write port.

Verification
REQ-037 reload pulse, sram_size=0, sdram_ready=1, HOLD_CYCLES=16 -> msx_reset high 16 hold cycles plus 1 WAIT_RDY cycle, no clr_req.
REQ-038 reload, sram_size=1, ack one cycle after each req -> 1024 writes, addr 0..1023, data 8'hFF, then WAIT_RDY.
REQ-039 sram_size=64 -> exactly 32768 writes, last addr 15'h7FFF, no wrap.
REQ-040 hps_reset during CLEAR at addr 100 -> write 100 completes, FSM returns to HOLD, and a full clear restarts at addr 0.
REQ-041 sdram_ready held low 50 cycles after clear -> msx_reset stays high until 1 cycle after ready rises.
REQ-042 reset asserted mid-CLEAR with a pending ack -> clr_req low next cycle, busy=0, the stray ack causes no address change.
